// File: rtl/conv_oc_scheduler.sv
// Output-channel sequencer for the 3x5x5 sum PE: fires the PE once per channel,
// requantizes the sum (bias, ReLU, shift, saturate) and streams 8-bit activations.
module conv_oc_scheduler #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned NUM_OC  = 4,
  parameter int unsigned NUM_POS = 784,
  parameter int unsigned SHIFT   = 7,
  localparam int unsigned OC_W   = (NUM_OC  > 1) ? $clog2(NUM_OC)  : 1,
  localparam int unsigned POS_W  = (NUM_POS > 1) ? $clog2(NUM_POS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       win_valid,
  output logic                       win_ready,
  output logic                       pe_valid,
  output logic [OC_W-1:0]            pe_wsel,
  input  logic [ACC_W-1:0]           pe_sum,
  input  logic                       pe_sum_valid,
  input  logic [NUM_OC*ACC_W-1:0]    bias_flat,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OC_W-1:0]            out_oc,
  output logic                       out_eof,
  output logic                       err
);

  localparam int unsigned T_W     = ACC_W + 1;
  localparam int unsigned ACT_MAX = (1 << (DATA_W - 1)) - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [OC_W-1:0]    oc;
  logic [POS_W-1:0]   pos;
  logic               last_oc;
  logic               last_pos;
  logic               capture;
  logic               accept;
  logic               pe_valid_nx;
  logic               win_ready_nx;
  logic [ACC_W-1:0]   bias_sel;
  logic [T_W-1:0]     t_sum;
  logic [T_W-1:0]     t_shift;
  logic [DATA_W-1:0]  act;

  assign last_oc  = (oc  == OC_W'(NUM_OC - 1));
  assign last_pos = (pos == POS_W'(NUM_POS - 1));
  assign pe_wsel  = oc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nx     = state;
    capture      = 1'b0;
    accept       = 1'b0;
    pe_valid_nx  = 1'b0;
    win_ready_nx = 1'b0;
    case (state)
      S_IDLE:  if (win_valid) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (pe_sum_valid) begin
          capture  = 1'b1;
          state_nx = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          accept   = 1'b1;
          state_nx = last_oc ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    pe_valid_nx  = (state_nx == S_ISSUE);
    win_ready_nx = (state_nx == S_DONE);
  end

  // Per-channel bias; channel 0 sits in the MSBs
  always_comb begin
    bias_sel = '0;
    for (int unsigned i = 0; i < NUM_OC; i++) begin
      if (oc == OC_W'(i)) bias_sel = bias_flat[(NUM_OC - 1 - i) * ACC_W +: ACC_W];
    end
  end

  // Requantize: widened add cannot overflow, then ReLU, shift, clamp
  always_comb begin
    t_sum   = {pe_sum[ACC_W-1], pe_sum} + {bias_sel[ACC_W-1], bias_sel};
    t_shift = t_sum >> SHIFT;
    act     = '0;
    if (t_sum[T_W-1]) begin
      act = '0;
    end else if (t_shift > T_W'(ACT_MAX)) begin
      act = DATA_W'(ACT_MAX);
    end else begin
      act = t_shift[DATA_W-1:0];
    end
  end

  // Registered outputs, channel/position counters and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_valid  <= 1'b0;
      win_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_oc    <= '0;
      out_eof   <= 1'b0;
      oc        <= '0;
      pos       <= '0;
      err       <= 1'b0;
    end else begin
      pe_valid  <= pe_valid_nx;
      win_ready <= win_ready_nx;
      if (capture) begin
        out_valid <= 1'b1;
        out_data  <= act;
        out_oc    <= oc;
        out_eof   <= last_oc && last_pos;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (accept && !last_oc) begin
        oc <= oc + OC_W'(1);
      end else if (state == S_DONE) begin
        oc <= '0;
      end
      if (state == S_DONE) begin
        pos <= last_pos ? '0 : pos + POS_W'(1);
      end
      if (pe_sum_valid && state != S_WAIT) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_oc_scheduler.sv
// Bench for conv_oc_scheduler with a 1-cycle PE model, vector table, random windows
// and directed backpressure / stray-valid / mid-window reset sequences.
module tb_conv_oc_scheduler;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ACC_W   = 24;
  localparam int unsigned NUM_OC  = 2;
  localparam int unsigned NUM_POS = 3;
  localparam int unsigned SHIFT   = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    win_valid = 1'b0;
  logic                    win_ready;
  logic                    pe_valid;
  logic [0:0]              pe_wsel;
  logic [ACC_W-1:0]        pe_sum = '0;
  logic                    pe_sum_valid;
  logic [NUM_OC*ACC_W-1:0] bias_flat = '0;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [0:0]              out_oc;
  logic                    out_eof;
  logic                    err;

  conv_oc_scheduler #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_OC(NUM_OC), .NUM_POS(NUM_POS), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .win_ready(win_ready),
    .pe_valid(pe_valid), .pe_wsel(pe_wsel), .pe_sum(pe_sum), .pe_sum_valid(pe_sum_valid),
    .bias_flat(bias_flat), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_oc(out_oc), .out_eof(out_eof), .err(err)
  );

  always #5 clk = ~clk;

  // PE model: one-cycle latency, sum chosen by the weight select
  logic [ACC_W-1:0] sum_tab [NUM_OC];
  logic             pe_sv_q = 1'b0;
  logic             inject = 1'b0;
  always @(posedge clk) begin
    pe_sv_q <= pe_valid;
    if (pe_valid) pe_sum <= sum_tab[pe_wsel];
  end
  assign pe_sum_valid = pe_sv_q | inject;

  int cyc = 0;
  int pe_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (pe_valid === 1'b1) pe_q.push_back(cyc);

  int nchk = 0;
  int nerr = 0;
  int pos_model = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint ref_act(input longint s, input longint b);
    longint t;
    t = s + b;
    if (t < 0) return 0;
    t = t >>> SHIFT;
    if (t > 127) return 127;
    return t;
  endfunction

  task automatic run_window(input longint s0, input longint s1, input longint b0, input longint b1,
                            input longint e0, input longint e1, input int stall, output bit eof1);
    longint ev[2];
    int hs[2];
    int n;
    logic [DATA_W-1:0] held;
    ev[0] = e0; ev[1] = e1;
    hs[0] = 0; hs[1] = 0;
    eof1 = 1'b0;
    sum_tab[0] = ACC_W'(s0);
    sum_tab[1] = ACC_W'(s1);
    bias_flat  = {ACC_W'(b0), ACC_W'(b1)};
    pe_q.delete();
    out_ready = (stall == 0);
    win_valid = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      if (!out_valid) begin
        chk("out_valid timeout", 0, 1);
        win_valid = 1'b0; out_ready = 1'b1;
        return;
      end
      chk("out_oc", out_oc, ch);
      chk("out_data", out_data, ev[ch]);
      chk("out_eof", out_eof, (ch == 1 && pos_model == NUM_POS - 1));
      if (ch == 1) eof1 = out_eof;
      if (ch == 0 && stall > 0) begin
        held = out_data;
        repeat (stall) begin
          @(negedge clk);
          chk("stall out_valid", out_valid, 1);
          chk("stall out_data", out_data, held);
          chk("stall out_oc", out_oc, 0);
          chk("stall pe_valid", pe_valid, 0);
        end
        out_ready = 1'b1;
      end
      hs[ch] = cyc;
      @(negedge clk);
      chk("out_valid drop", out_valid, 0);
    end
    chk("win_ready", win_ready, 1);
    win_valid = 1'b0;
    chk("pe_valid count", pe_q.size(), 2);
    if (pe_q.size() == 2) begin
      chk("pe_valid after accept", pe_q[1], hs[0] + 1);
      if (stall == 0) chk("pe_valid spacing", pe_q[1] - pe_q[0], 3);
    end
    @(negedge clk);
    chk("win_ready pulse", win_ready, 0);
    pos_model = (pos_model + 1) % NUM_POS;
  endtask

  typedef struct {
    longint s0, s1, b0, b1;
    longint e0, e1;
    int     stall;
  } vec_t;

  vec_t tab[8];
  bit   eof_got;
  int   frame_eof[4];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{1000, 1000, 10, -50, 63, 59, 0};
    tab[1] = '{5000, 10, 10, -50, 127, 0, 5};
    tab[2] = '{-8388608, -8388608, -1, -1, 0, 0, 0};
    tab[3] = '{8388607, 0, 8388607, 15, 127, 0, 0};
    tab[4] = '{15, 16, 0, 0, 0, 1, 1};
    tab[5] = '{2047, -16, 0, 15, 127, 0, 0};
    tab[6] = '{100, 200, -100, -199, 0, 0, 2};
    tab[7] = '{2048, 2031, -1, 0, 127, 126, 0};
    frame_eof[0] = 0; frame_eof[1] = 0; frame_eof[2] = 1; frame_eof[3] = 0;
    sum_tab[0] = '0; sum_tab[1] = '0;

    repeat (3) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset pe_valid", pe_valid, 0);
    chk("reset win_ready", win_ready, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_oc", out_oc, 0);
    chk("reset pe_wsel", pe_wsel, 0);
    chk("reset err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_window(tab[i].s0, tab[i].s1, tab[i].b0, tab[i].b1, tab[i].e0, tab[i].e1, tab[i].stall, eof_got);
    end
    chk("err clean", err, 0);

    // Stray PE valid while idle
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    chk("err set", err, 1);
    chk("stray no out_valid", out_valid, 0);
    run_window(1000, 1000, 10, -50, 63, 59, 0, eof_got);
    chk("err sticky", err, 1);

    // Random windows against the reference model
    for (int i = 0; i < 40; i++) begin
      longint s0, s1, b0, b1;
      if ($urandom_range(0, 1) == 1) begin
        s0 = longint'($signed(ACC_W'($urandom)));
        s1 = longint'($signed(ACC_W'($urandom)));
      end else begin
        s0 = longint'($urandom_range(0, 4000)) - 1000;
        s1 = longint'($urandom_range(0, 4000)) - 1000;
      end
      b0 = longint'($urandom_range(0, 400)) - 200;
      b1 = longint'($urandom_range(0, 400)) - 200;
      run_window(s0, s1, b0, b1, ref_act(s0, b0), ref_act(s1, b1), int'($urandom_range(0, 3)), eof_got);
    end
    chk("err sticky after random", err, 1);

    // Reset while holding a result under backpressure
    sum_tab[0] = ACC_W'(500);
    sum_tab[1] = ACC_W'(500);
    out_ready = 1'b0;
    win_valid = 1'b1;
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    chk("pre-reset out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset pe_valid", pe_valid, 0);
    chk("async reset win_ready", win_ready, 0);
    chk("async reset err", err, 0);
    win_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    pos_model = 0;
    @(negedge clk);
    chk("post-reset pe_wsel", pe_wsel, 0);

    // Frame boundary: eof only on the last channel of the third window
    for (int w = 0; w < 4; w++) begin
      run_window(300 + 16 * w, 700, 0, -300, ref_act(300 + 16 * w, 0), 25, 0, eof_got);
      chk("frame eof", eof_got, frame_eof[w]);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
